tpu_seq_ctrl: RTL and testbench
===============================

// Module: tpu_seq_ctrl
// PURPOSE
//  Compute sequencer for the tpuv1 systolic matmul array. Sits between the host write port and the array.
//  On start it walks the array through a FEED phase (DIM cycles, column k of A / row k of B into the skew regs)
//  and a DRAIN phase (2*DIM-2 cycles of zero feed), then reports done.
//  It also gates host writes to the A/B/C buffers while a computation is in flight.
// PARAMETERS
//  DIM      32   array dimension (rows = cols = DIM); legal range 2..64
//  CNT_W    $clog2(2*DIM)   phase counter width (derived, not overridden)
// PORTS
//  clk          in   1       single clock, rising-edge
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       host request to begin C += A*B; level sampled each edge
//  WrEnA        in   1       host write request, A buffer
//  WrEnB        in   1       host write request, B buffer
//  WrEnC        in   1       host write request, C accumulators
//  wr_a         out  1       gated write enable to A buffer
//  wr_b         out  1       gated write enable to B buffer
//  wr_c         out  1       gated write enable to C accumulators
//  feed_en      out  1       A/B buffers present column/row feed_k to skew regs this cycle
//  feed_k       out  $clog2(DIM)  index of A column / B row being fed
//  mac_en       out  1       array PEs shift and accumulate this cycle
//  busy         out  1       computation in flight
//  done         out  1       level: last computation complete, C valid for readback
//  wr_drop      out  1       sticky: a host write arrived while busy and was discarded
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - All outputs 0, state IDLE, counter 0.
//  States: IDLE -> FEED -> DRAIN -> IDLE
//  IDLE
//   - wr_x = WrEnx (combinational pass-through).
//   - start=1 at edge E0 -> FEED, cnt=0.
//   - done cleared at E0; also cleared by any accepted write.
//  FEED
//   - busy=1, mac_en=1, feed_en=1, feed_k=cnt.
//   - cnt==DIM-1 -> DRAIN, cnt=0.
//  DRAIN
//   - busy=1, mac_en=1, feed_en=0, feed_k=0.
//   - cnt==2*DIM-3 -> IDLE, done=1.
//  Latency
//   - mac_en high for exactly 3*DIM-2 consecutive cycles starting the cycle after E0.
//   - busy falls and done rises at edge E0+3*DIM-2 (94 for DIM=32).
//  Boundaries
//   - start while busy: ignored, no restart, no effect on counters.
//   - start and WrEnx in the same IDLE cycle: the write is accepted (commits at E0) and the computation starts.
//   - WrEnx while busy: wr_x=0; wr_drop set, held until reset or the next start accepted from IDLE.
//   - start held high across completion: new run begins the edge after returning to IDLE (one IDLE cycle with done=1).
//   - rst_n low mid-FEED/DRAIN: immediate IDLE, all outputs 0; array contents are the array's concern.
//   - feed_k never exceeds DIM-1; cnt never exceeds 2*DIM-3.
// STRUCTURE
//  tpu_pkg (shared)
//   - DIM default.
//   - typedef enum logic [1:0] {IDLE, FEED, DRAIN} tpu_seq_state_t.
//   - function drain_len(DIM) = 2*DIM-2.
//  Implementation
//   - No sub-module: one state register, one CNT_W counter, combinational output decode.
//   - Outputs are registered except the wr_x gates.
// TESTING (run at DIM=4 and DIM=32)
//  1. Reset mid-FEED (rst_n low at cycle 3 after start, DIM=4) -> all outputs 0 same cycle, IDLE.
//     Next start gives a full 10-cycle run.
//  2. Single start pulse, DIM=4
//     -> feed_k = 0,1,2,3 with feed_en; mac_en high 10 cycles; done rises at edge E0+10; busy low same edge.
//  3. WrEnA pulse 3 cycles after start
//     -> wr_a stays 0, wr_drop=1 until next start.
//     Same pulse in IDLE -> wr_a=1, done cleared.
//  4. start re-pulsed mid-DRAIN -> ignored; done still at E0+10, not extended.
//  5. start tied high, DIM=4 -> back-to-back runs of 10 mac_en cycles separated by one IDLE cycle with done=1.
//  6. Full system, DIM=32
//     - Load random A, B via host; start -> done at E0+94.
//     - C matches the reference product.
//     - A second run with preloaded C gives C_init + A*B.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the tpuv1 matmul sequencer.
package tpu_pkg;

  localparam int unsigned DIM_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN
  } tpu_seq_state_t;

  // Zero-feed cycles needed to flush the skewed wavefront out of the array.
  function automatic int unsigned drain_len(input int unsigned dim);
    return 2 * dim - 2;
  endfunction

endpackage

// File: rtl/tpu_seq_ctrl.sv
// Compute sequencer for the systolic matmul array: FEED/DRAIN walk plus host write gating.
module tpu_seq_ctrl
  import tpu_pkg::*;
#(
  parameter int unsigned DIM = DIM_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   WrEnA,
  input  logic                   WrEnB,
  input  logic                   WrEnC,
  output logic                   wr_a,
  output logic                   wr_b,
  output logic                   wr_c,
  output logic                   feed_en,
  output logic [$clog2(DIM)-1:0] feed_k,
  output logic                   mac_en,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_drop
);

  localparam int unsigned CNT_W = $clog2(2 * DIM);
  localparam int unsigned K_W   = $clog2(DIM);

  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(drain_len(DIM) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  tpu_seq_state_t   state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             feed_en_q;
  logic [K_W-1:0]   feed_k_q;
  logic             done_q;
  logic             drop_q;
  logic             any_wr;

  assign any_wr = WrEnA | WrEnB | WrEnC;

  // Host writes pass straight through while idle and are discarded while a run is in flight.
  always_comb begin
    wr_a = WrEnA & ~busy_q;
    wr_b = WrEnB & ~busy_q;
    wr_c = WrEnC & ~busy_q;
  end

  assign busy    = busy_q;
  assign mac_en  = busy_q;
  assign feed_en = feed_en_q;
  assign feed_k  = feed_k_q;
  assign done    = done_q;
  assign wr_drop = drop_q;

  // Sequencer FSM with registered status outputs; next-cycle output values are set on each transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      feed_en_q <= 1'b0;
      feed_k_q  <= '0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= FEED;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            feed_en_q <= 1'b1;
            feed_k_q  <= '0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
          end else if (any_wr) begin
            // An accepted write invalidates the previous result.
            done_q <= 1'b0;
          end
        end
        FEED: begin
          if (any_wr) drop_q <= 1'b1;
          if (cnt_q == FEED_LAST) begin
            state_q   <= DRAIN;
            cnt_q     <= '0;
            feed_en_q <= 1'b0;
            feed_k_q  <= '0;
          end else begin
            cnt_q    <= cnt_q + CNT_ONE;
            feed_k_q <= K_W'(cnt_q + CNT_ONE);
          end
        end
        DRAIN: begin
          if (any_wr) drop_q <= 1'b1;
          if (cnt_q == DRAIN_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Randomized self-checking bench: DIM=4 and DIM=32 sequencers against a run-position model,
// with a behavioural outer-product array on the DIM=32 instance checking C += A*B.
module tb_tpu_seq_ctrl;

  localparam int D0 = 4;
  localparam int D1 = 32;

  logic clk;
  logic rst_n;
  logic start   [2];
  logic wen_a   [2];
  logic wen_b   [2];
  logic wen_c   [2];
  logic wr_a    [2];
  logic wr_b    [2];
  logic wr_c    [2];
  logic feed_en [2];
  logic mac_en  [2];
  logic busy    [2];
  logic done    [2];
  logic wr_drop [2];
  logic [1:0] feed_k0;
  logic [4:0] feed_k1;

  int n_checks;
  int n_errors;

  // Model: pos = cycles elapsed since the accepting edge (-1 when idle).
  int pos     [2];
  bit done_m  [2];
  bit drop_m  [2];
  int mac_run [2];
  int feed_run[2];

  int a_host[D1][D1];
  int b_host[D1][D1];
  int c_host[D1][D1];
  int a_buf [D1][D1];
  int b_buf [D1][D1];
  int c_arr [D1][D1];
  int c_ref [D1][D1];
  bit pin_ones;

  tpu_seq_ctrl #(.DIM(D0)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start[0]),
    .WrEnA  (wen_a[0]),
    .WrEnB  (wen_b[0]),
    .WrEnC  (wen_c[0]),
    .wr_a   (wr_a[0]),
    .wr_b   (wr_b[0]),
    .wr_c   (wr_c[0]),
    .feed_en(feed_en[0]),
    .feed_k (feed_k0),
    .mac_en (mac_en[0]),
    .busy   (busy[0]),
    .done   (done[0]),
    .wr_drop(wr_drop[0])
  );

  tpu_seq_ctrl #(.DIM(D1)) u_dut32 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start[1]),
    .WrEnA  (wen_a[1]),
    .WrEnB  (wen_b[1]),
    .WrEnC  (wen_c[1]),
    .wr_a   (wr_a[1]),
    .wr_b   (wr_b[1]),
    .wr_c   (wr_c[1]),
    .feed_en(feed_en[1]),
    .feed_k (feed_k1),
    .mac_en (mac_en[1]),
    .busy   (busy[1]),
    .done   (done[1]),
    .wr_drop(wr_drop[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input int inst, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dim=%0d t=%0t: got %0d expected %0d", nm, (inst == 0) ? D0 : D1,
               $time, act, exp);
    end
  endtask

  // Reference result taken when a run is accepted: C_ref = C + A*B.
  task automatic snapshot_ref();
    for (int i = 0; i < D1; i++)
      for (int j = 0; j < D1; j++) begin
        int s;
        s = c_arr[i][j];
        for (int k = 0; k < D1; k++) s += a_buf[i][k] * b_buf[k][j];
        c_ref[i][j] = s;
      end
  endtask

  task automatic check_c();
    int nmis;
    nmis = 0;
    for (int i = 0; i < D1; i++)
      for (int j = 0; j < D1; j++)
        if (c_arr[i][j] != c_ref[i][j]) nmis++;
    chk(1, "c_matrix_mismatches", nmis, 0);
    if (pin_ones) chk(1, "c_pin_ones_times_twos", c_arr[5][7], 64);
  endtask

  // Single compare process: check every cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int d;
      int fk;
      bit eb;
      bit ef;
      bit any;
      d  = (i == 0) ? D0 : D1;
      fk = (i == 0) ? int'(feed_k0) : int'(feed_k1);
      if (!rst_n) begin
        pos[i]    = -1;
        done_m[i] = 1'b0;
        drop_m[i] = 1'b0;
      end
      eb = (pos[i] >= 0);
      ef = eb && (pos[i] < d);
      chk(i, "busy", busy[i], eb);
      chk(i, "mac_en", mac_en[i], eb);
      chk(i, "feed_en", feed_en[i], ef);
      chk(i, "feed_k", fk, ef ? pos[i] : 0);
      chk(i, "done", done[i], done_m[i]);
      chk(i, "wr_drop", wr_drop[i], drop_m[i]);
      chk(i, "wr_a", wr_a[i], wen_a[i] && !eb);
      chk(i, "wr_b", wr_b[i], wen_b[i] && !eb);
      chk(i, "wr_c", wr_c[i], wen_c[i] && !eb);

      // Hand-computed run lengths: 3*DIM-2 mac cycles, DIM feed cycles.
      if (mac_en[i] === 1'b1) mac_run[i]++;
      else begin
        if (mac_run[i] > 0 && rst_n) chk(i, "mac_run_len", mac_run[i], (i == 0) ? 10 : 94);
        mac_run[i] = 0;
      end
      if (feed_en[i] === 1'b1) feed_run[i]++;
      else begin
        if (feed_run[i] > 0 && rst_n) chk(i, "feed_run_len", feed_run[i], (i == 0) ? 4 : 32);
        feed_run[i] = 0;
      end

      if (rst_n) begin
        // Behavioural array on the DIM=32 instance: one outer-product term per fed index.
        if (i == 1) begin
          if (feed_en[1] === 1'b1)
            for (int r = 0; r < D1; r++)
              for (int c = 0; c < D1; c++)
                c_arr[r][c] += a_buf[r][feed_k1] * b_buf[feed_k1][c];
          if (wr_a[1] === 1'b1) a_buf = a_host;
          if (wr_b[1] === 1'b1) b_buf = b_host;
          if (wr_c[1] === 1'b1) c_arr = c_host;
        end
        any = wen_a[i] || wen_b[i] || wen_c[i];
        if (pos[i] < 0) begin
          if (start[i]) begin
            pos[i]    = 0;
            done_m[i] = 1'b0;
            drop_m[i] = 1'b0;
            if (i == 1) snapshot_ref();
          end else if (any) begin
            done_m[i] = 1'b0;
          end
        end else begin
          if (any) drop_m[i] = 1'b1;
          if (pos[i] == 3 * d - 3) begin
            pos[i]    = -1;
            done_m[i] = 1'b1;
            if (i == 1) check_c();
          end else begin
            pos[i]++;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic fill_host(input int sel, input bit rnd, input int val);
    for (int i = 0; i < D1; i++)
      for (int j = 0; j < D1; j++) begin
        int v;
        v = rnd ? int'($urandom_range(0, 255)) : val;
        if (sel == 0) a_host[i][j] = v;
        else if (sel == 1) b_host[i][j] = v;
        else c_host[i][j] = v;
      end
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    step(1);
    start[i] = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    pin_ones = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      wen_a[i] = 1'b0;
      wen_b[i] = 1'b0;
      wen_c[i] = 1'b0;
    end
    step(3);
    rst_n = 1'b1;
    step(2);

    // Single start pulse.
    pulse_start(0);
    step(14);

    // Reset mid-FEED, then a full run.
    pulse_start(0);
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    pulse_start(0);
    step(14);

    // Write while busy is dropped; write in idle clears done; next start clears drop.
    pulse_start(0);
    step(2);
    wen_a[0] = 1'b1;
    step(1);
    wen_a[0] = 1'b0;
    step(12);
    wen_a[0] = 1'b1;
    step(1);
    wen_a[0] = 1'b0;
    step(2);
    pulse_start(0);
    step(12);

    // Start re-pulsed mid-DRAIN is ignored.
    pulse_start(0);
    step(6);
    pulse_start(0);
    step(12);

    // Start and write in the same idle cycle.
    wen_b[0] = 1'b1;
    start[0] = 1'b1;
    step(1);
    wen_b[0] = 1'b0;
    start[0] = 1'b0;
    step(12);

    // Start tied high: back-to-back runs.
    start[0] = 1'b1;
    step(35);
    start[0] = 1'b0;
    step(12);

    // Random stimulus on DIM=4 including occasional resets.
    for (int c = 0; c < 400; c++) begin
      start[0] = ($urandom_range(0, 9) == 0);
      wen_a[0] = ($urandom_range(0, 7) == 0);
      wen_b[0] = ($urandom_range(0, 7) == 0);
      wen_c[0] = ($urandom_range(0, 7) == 0);
      rst_n    = ($urandom_range(0, 149) != 0);
      step(1);
    end
    start[0] = 1'b0;
    wen_a[0] = 1'b0;
    wen_b[0] = 1'b0;
    wen_c[0] = 1'b0;
    rst_n    = 1'b1;
    step(12);

    // DIM=32: A all ones, B all twos, C zero -> every C element is 64.
    fill_host(0, 1'b0, 1);
    fill_host(1, 1'b0, 2);
    fill_host(2, 1'b0, 0);
    wen_a[1] = 1'b1;
    wen_b[1] = 1'b1;
    wen_c[1] = 1'b1;
    step(1);
    wen_a[1] = 1'b0;
    wen_b[1] = 1'b0;
    wen_c[1] = 1'b0;
    pin_ones = 1'b1;
    pulse_start(1);
    step(100);
    pin_ones = 1'b0;

    // Random A, B with zero C, then a second run on a random preloaded C.
    for (int run = 0; run < 2; run++) begin
      fill_host(0, 1'b1, 0);
      fill_host(1, 1'b1, 0);
      fill_host(2, (run == 1), 0);
      wen_a[1] = 1'b1;
      wen_b[1] = 1'b1;
      wen_c[1] = 1'b1;
      step(1);
      wen_a[1] = 1'b0;
      wen_b[1] = 1'b0;
      wen_c[1] = 1'b0;
      pulse_start(1);
      step(100);
    end

    // Random stimulus on DIM=32: host data changes with every write attempt.
    for (int c = 0; c < 400; c++) begin
      start[1] = ($urandom_range(0, 29) == 0);
      wen_a[1] = ($urandom_range(0, 19) == 0);
      wen_b[1] = ($urandom_range(0, 19) == 0);
      wen_c[1] = ($urandom_range(0, 19) == 0);
      if (wen_a[1]) fill_host(0, 1'b1, 0);
      if (wen_b[1]) fill_host(1, 1'b1, 0);
      if (wen_c[1]) fill_host(2, 1'b1, 0);
      step(1);
    end
    start[1] = 1'b0;
    wen_a[1] = 1'b0;
    wen_b[1] = 1'b0;
    wen_c[1] = 1'b0;
    step(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
